// File: rtl/me_pkg.sv
// Shared constants and FSM encoding for the motion-estimation SAD datapath.
package me_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 16;
  localparam int unsigned NUM_PE         = 4;
  localparam int unsigned NUM_POS        = 256;
  localparam int unsigned IDX_WIDTH      = 8;
  localparam int unsigned SW_COLS        = 16;
  localparam int unsigned SEARCH_RANGE   = 8;
  localparam int unsigned MV_WIDTH       = 6;

  localparam logic [MAX_DATA_WIDTH-1:0] SAD_INIT = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/sad_min_tree.sv
// Combinational NUM_PE-input minimum over masked lanes; equal SADs resolve to the lower index.
module sad_min_tree #(
  parameter int unsigned MAX_DATA_WIDTH = 16,
  parameter int unsigned NUM_PE         = 4,
  parameter int unsigned IDX_WIDTH      = 8
) (
  input  logic [NUM_PE*MAX_DATA_WIDTH-1:0] in_sad,
  input  logic [NUM_PE*IDX_WIDTH-1:0]      in_idx,
  input  logic [NUM_PE-1:0]                in_mask,
  output logic [MAX_DATA_WIDTH-1:0]        out_min_sad,
  output logic [IDX_WIDTH-1:0]             out_min_idx,
  output logic                             out_any_valid
);

  logic [MAX_DATA_WIDTH-1:0] lane_sad [NUM_PE];
  logic [IDX_WIDTH-1:0]      lane_idx [NUM_PE];

  always_comb begin
    for (int unsigned l = 0; l < NUM_PE; l++) begin
      lane_sad[l] = in_sad[l*MAX_DATA_WIDTH +: MAX_DATA_WIDTH];
      lane_idx[l] = in_idx[l*IDX_WIDTH +: IDX_WIDTH];
    end
  end

  // Index is compared explicitly: staggered lanes can present a lower index on a higher lane.
  always_comb begin
    out_min_sad   = '1;
    out_min_idx   = '0;
    out_any_valid = 1'b0;
    for (int unsigned l = 0; l < NUM_PE; l++) begin
      if (in_mask[l]) begin
        if (!out_any_valid ||
            (lane_sad[l] < out_min_sad) ||
            ((lane_sad[l] == out_min_sad) && (lane_idx[l] < out_min_idx))) begin
          out_min_sad   = lane_sad[l];
          out_min_idx   = lane_idx[l];
          out_any_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sad_min_selector.sv
// Collects per-lane SAD results over one search, keeps the running minimum and
// converts the winning candidate index into a centred signed motion vector.
module sad_min_selector #(
  parameter int unsigned MAX_DATA_WIDTH = me_pkg::MAX_DATA_WIDTH,
  parameter int unsigned NUM_PE         = me_pkg::NUM_PE,
  parameter int unsigned NUM_POS        = me_pkg::NUM_POS,
  parameter int unsigned IDX_WIDTH      = me_pkg::IDX_WIDTH,
  parameter int unsigned SW_COLS        = me_pkg::SW_COLS,
  parameter int unsigned SEARCH_RANGE   = me_pkg::SEARCH_RANGE,
  parameter int unsigned MV_WIDTH       = me_pkg::MV_WIDTH
) (
  input  logic                             in_clk,
  input  logic                             in_rst,
  input  logic                             in_start,
  input  logic [NUM_PE*MAX_DATA_WIDTH-1:0] in_sad,
  input  logic [NUM_PE-1:0]                in_sad_valid,
  output logic [MAX_DATA_WIDTH-1:0]        out_best_sad,
  output logic [IDX_WIDTH-1:0]             out_best_idx,
  output logic [MV_WIDTH-1:0]              out_mv_x,
  output logic [MV_WIDTH-1:0]              out_mv_y,
  output logic                             out_busy,
  output logic                             out_done,
  output logic                             out_overflow
);

  import me_pkg::*;

  localparam int unsigned COL_W    = $clog2(SW_COLS);
  localparam int unsigned LANE_POS = NUM_POS / NUM_PE;
  localparam int unsigned LCNT_W   = $clog2(LANE_POS + 1);
  localparam int unsigned ACC_W    = $clog2(NUM_POS + 1);

  state_t state, state_nxt;

  logic [LCNT_W-1:0]          lane_cnt [NUM_PE];
  logic [ACC_W-1:0]           acc_cnt;
  logic                       have_best;

  logic [31:0]                lane_idx [NUM_PE];
  logic [NUM_PE*IDX_WIDTH-1:0] cand_idx;
  logic [NUM_PE-1:0]          accept;
  logic                       ovf_hit;
  logic [ACC_W-1:0]           acc_add;

  logic [MAX_DATA_WIDTH-1:0]  tree_sad;
  logic [IDX_WIDTH-1:0]       tree_idx;
  logic                       tree_valid;
  logic                       replace;
  logic [MV_WIDTH-1:0]        mv_x_nxt;
  logic [MV_WIDTH-1:0]        mv_y_nxt;

  // Lane l's k-th accepted result is candidate k*NUM_PE + l.
  always_comb begin
    for (int unsigned l = 0; l < NUM_PE; l++) begin
      lane_idx[l] = 32'(lane_cnt[l]) * NUM_PE + l;
    end
  end

  always_comb begin
    accept   = '0;
    ovf_hit  = 1'b0;
    acc_add  = '0;
    cand_idx = '0;
    for (int unsigned l = 0; l < NUM_PE; l++) begin
      cand_idx[l*IDX_WIDTH +: IDX_WIDTH] = lane_idx[l][IDX_WIDTH-1:0];
      if ((state == ST_COLLECT) && in_sad_valid[l]) begin
        if (lane_idx[l] < NUM_POS) begin
          accept[l] = 1'b1;
          acc_add   = acc_add + ACC_W'(1);
        end else begin
          ovf_hit = 1'b1;
        end
      end
    end
  end

  sad_min_tree #(
    .MAX_DATA_WIDTH (MAX_DATA_WIDTH),
    .NUM_PE         (NUM_PE),
    .IDX_WIDTH      (IDX_WIDTH)
  ) u_min_tree (
    .in_sad        (in_sad),
    .in_idx        (cand_idx),
    .in_mask       (accept),
    .out_min_sad   (tree_sad),
    .out_min_idx   (tree_idx),
    .out_any_valid (tree_valid)
  );

  // With no stored best yet, any accepted candidate (even all-ones SAD) wins.
  always_comb begin
    replace = tree_valid &&
              (!have_best ||
               (tree_sad < out_best_sad) ||
               ((tree_sad == out_best_sad) && (tree_idx < out_best_idx)));
    mv_x_nxt = MV_WIDTH'(tree_idx[COL_W-1:0]) - MV_WIDTH'(SEARCH_RANGE);
    mv_y_nxt = MV_WIDTH'(tree_idx[IDX_WIDTH-1:COL_W]) - MV_WIDTH'(SEARCH_RANGE);
  end

  always_comb begin
    state_nxt = state;
    if (in_start) begin
      state_nxt = ST_COLLECT;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_IDLE;
        ST_COLLECT: if (acc_cnt == ACC_W'(NUM_POS)) state_nxt = ST_DONE;
        ST_DONE:    state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_best_sad <= '1;
      out_best_idx <= '0;
      out_mv_x     <= '0;
      out_mv_y     <= '0;
      out_overflow <= 1'b0;
      have_best    <= 1'b0;
      acc_cnt      <= '0;
      for (int unsigned l = 0; l < NUM_PE; l++) lane_cnt[l] <= '0;
    end else if (in_start) begin
      out_best_sad <= '1;
      out_best_idx <= '0;
      out_mv_x     <= '0;
      out_mv_y     <= '0;
      out_overflow <= 1'b0;
      have_best    <= 1'b0;
      acc_cnt      <= '0;
      for (int unsigned l = 0; l < NUM_PE; l++) lane_cnt[l] <= '0;
    end else begin
      if (ovf_hit) out_overflow <= 1'b1;
      for (int unsigned l = 0; l < NUM_PE; l++) begin
        if (accept[l]) lane_cnt[l] <= lane_cnt[l] + LCNT_W'(1);
      end
      acc_cnt <= acc_cnt + acc_add;
      if (replace) begin
        out_best_sad <= tree_sad;
        out_best_idx <= tree_idx;
        out_mv_x     <= mv_x_nxt;
        out_mv_y     <= mv_y_nxt;
        have_best    <= 1'b1;
      end
    end
  end

  assign out_busy = (state == ST_COLLECT);
  assign out_done = (state == ST_DONE);

endmodule

// File: tb/tb_sad_min_selector.sv
// Directed bench for sad_min_selector: sweeps, ties, overflow, restart and reset.
module tb_sad_min_selector;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_start;
  logic [63:0] in_sad;
  logic [3:0]  in_sad_valid;
  logic [15:0] out_best_sad;
  logic [7:0]  out_best_idx;
  logic [5:0]  out_mv_x;
  logic [5:0]  out_mv_y;
  logic        out_busy;
  logic        out_done;
  logic        out_overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  sad_min_selector #(
    .MAX_DATA_WIDTH (16),
    .NUM_PE         (4),
    .NUM_POS        (256),
    .IDX_WIDTH      (8),
    .SW_COLS        (16),
    .SEARCH_RANGE   (8),
    .MV_WIDTH       (6)
  ) dut (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .in_start     (in_start),
    .in_sad       (in_sad),
    .in_sad_valid (in_sad_valid),
    .out_best_sad (out_best_sad),
    .out_best_idx (out_best_idx),
    .out_mv_x     (out_mv_x),
    .out_mv_y     (out_mv_y),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .out_overflow (out_overflow)
  );

  always #5 in_clk = ~in_clk;

  always @(negedge in_clk) if (out_done) done_cnt++;

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic start_search();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  task automatic pulse(input int lane, input logic [15:0] sad);
    in_sad = '0;
    in_sad[lane*16 +: 16] = sad;
    in_sad_valid = 4'b0001 << lane;
    tick();
    in_sad_valid = '0;
  endtask

  task automatic round_all(input logic [15:0] s0, input logic [15:0] s1,
                           input logic [15:0] s2, input logic [15:0] s3);
    in_sad = {s3, s2, s1, s0};
    in_sad_valid = 4'b1111;
    tick();
    in_sad_valid = '0;
  endtask

  task automatic wait_done(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      if (out_done) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    in_rst = 1'b1; in_start = 1'b0; in_sad = '0; in_sad_valid = '0;
    repeat (3) tick();
    in_rst = 1'b0;
    tick();
    checks++; if (out_best_sad !== 16'hFFFF) begin errors++; $display("FAIL reset_sad got %h exp ffff", out_best_sad); end
    checks++; if (out_best_idx !== 8'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", out_best_idx); end
    checks++; if ({out_mv_x, out_mv_y} !== 12'd0) begin errors++; $display("FAIL reset_mv got %h/%h exp 0/0", out_mv_x, out_mv_y); end
    checks++; if ({out_busy, out_done, out_overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {out_busy, out_done, out_overflow}); end
  endtask

  task automatic test_idle_filter();
    bit seen;
    for (int i = 0; i < 4; i++) round_all(16'd0, 16'd0, 16'd0, 16'd0);
    checks++; if ({out_best_sad, out_busy, out_overflow} !== {16'hFFFF, 2'b00}) begin errors++; $display("FAIL idle_ignore got %h %b%b exp ffff 00", out_best_sad, out_busy, out_overflow); end
    start_search();
    for (int r = 0; r < 64; r++) round_all(r == 25 ? 16'd33 : 16'd400, 16'd400, 16'd400, 16'd400);
    wait_done(4, seen);
    checks++; if (!seen) begin errors++; $display("FAIL idle_search_done got 0 exp 1"); end
    round_all(16'd0, 16'd0, 16'd0, 16'd0);
    checks++; if ({out_best_sad, out_best_idx} !== {16'd33, 8'd100}) begin errors++; $display("FAIL done_ignore got %0d@%0d exp 33@100", out_best_sad, out_best_idx); end
    checks++; if ({out_mv_x, out_mv_y, out_overflow} !== {6'h3C, 6'h3E, 1'b0}) begin errors++; $display("FAIL idle_mv got %h %h %b exp 3c 3e 0", out_mv_x, out_mv_y, out_overflow); end
  endtask

  task automatic test_single_lane_sweep();
    bit seen;
    int d0;
    start_search();
    checks++; if (out_busy !== 1'b1) begin errors++; $display("FAIL sweep_busy got %b exp 1", out_busy); end
    d0 = done_cnt;
    for (int k = 0; k < 256; k++) pulse(k % 4, k == 37 ? 16'd12 : 16'd500);
    wait_done(4, seen);
    repeat (4) tick();
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL sweep_done_count got %0d exp 1", done_cnt - d0); end
    checks++; if ({out_best_sad, out_best_idx} !== {16'd12, 8'd37}) begin errors++; $display("FAIL sweep_best got %0d@%0d exp 12@37", out_best_sad, out_best_idx); end
    checks++; if ({out_mv_x, out_mv_y} !== {6'h3D, 6'h3A}) begin errors++; $display("FAIL sweep_mv got %h/%h exp 3d/3a", out_mv_x, out_mv_y); end
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL sweep_idle got %b exp 0", out_busy); end
  endtask

  task automatic test_simultaneous();
    bit seen;
    start_search();
    round_all(16'd90, 16'd40, 16'd40, 16'd70);
    checks++; if ({out_best_sad, out_best_idx} !== {16'd40, 8'd1}) begin errors++; $display("FAIL simul_round0 got %0d@%0d exp 40@1", out_best_sad, out_best_idx); end
    for (int r = 1; r < 64; r++) round_all(16'd100, 16'd100, 16'd100, 16'd100);
    wait_done(4, seen);
    checks++; if (!seen) begin errors++; $display("FAIL simul_done got 0 exp 1"); end
    checks++; if ({out_best_sad, out_best_idx} !== {16'd40, 8'd1}) begin errors++; $display("FAIL simul_best got %0d@%0d exp 40@1", out_best_sad, out_best_idx); end
    checks++; if ({out_mv_x, out_mv_y} !== {6'h39, 6'h38}) begin errors++; $display("FAIL simul_mv got %h/%h exp 39/38", out_mv_x, out_mv_y); end
  endtask

  task automatic test_tie_stored();
    start_search();
    for (int k = 0; k < 256; k++) pulse(k % 4, (k == 5 || k == 200) ? 16'd20 : 16'd300);
    checks++; if ({out_done, out_busy} !== 2'b01) begin errors++; $display("FAIL tie_edge0 got %b exp 01", {out_done, out_busy}); end
    tick();
    checks++; if ({out_done, out_busy} !== 2'b10) begin errors++; $display("FAIL tie_edge1 got %b exp 10", {out_done, out_busy}); end
    tick();
    checks++; if ({out_done, out_busy} !== 2'b00) begin errors++; $display("FAIL tie_edge2 got %b exp 00", {out_done, out_busy}); end
    checks++; if ({out_best_sad, out_best_idx} !== {16'd20, 8'd5}) begin errors++; $display("FAIL tie_best got %0d@%0d exp 20@5", out_best_sad, out_best_idx); end
  endtask

  task automatic test_all_ones();
    bit seen;
    start_search();
    for (int r = 0; r < 64; r++) round_all(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_done(4, seen);
    checks++; if (!seen) begin errors++; $display("FAIL ones_done got 0 exp 1"); end
    checks++; if ({out_best_sad, out_best_idx, out_mv_x, out_mv_y} !== {16'hFFFF, 8'd0, 6'h38, 6'h38}) begin
      errors++; $display("FAIL ones_best got %h@%0d mv %h/%h exp ffff@0 mv 38/38", out_best_sad, out_best_idx, out_mv_x, out_mv_y);
    end
  endtask

  task automatic test_overflow();
    start_search();
    for (int k = 0; k < 64; k++) pulse(2, k == 10 ? 16'd30 : 16'd300);
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", out_overflow); end
    pulse(2, 16'd0);
    checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", out_overflow); end
    checks++; if ({out_best_sad, out_best_idx, out_busy} !== {16'd30, 8'd42, 1'b1}) begin errors++; $display("FAIL ovf_best got %0d@%0d busy %b exp 30@42 busy 1", out_best_sad, out_best_idx, out_busy); end
    tick();
    checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", out_overflow); end
    start_search();
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", out_overflow); end
  endtask

  task automatic test_restart();
    bit seen;
    int d0;
    start_search();
    d0 = done_cnt;
    for (int k = 0; k < 100; k++) pulse(k % 4, k == 50 ? 16'd7 : 16'd200);
    checks++; if ({out_best_sad, out_best_idx} !== {16'd7, 8'd50}) begin errors++; $display("FAIL restart_pre got %0d@%0d exp 7@50", out_best_sad, out_best_idx); end
    start_search();
    checks++; if ({out_best_sad, out_best_idx, out_busy} !== {16'hFFFF, 8'd0, 1'b1}) begin errors++; $display("FAIL restart_clear got %h@%0d busy %b exp ffff@0 busy 1", out_best_sad, out_best_idx, out_busy); end
    for (int k = 0; k < 256; k++) pulse(k % 4, k == 3 ? 16'd9 : 16'd200);
    wait_done(4, seen);
    repeat (2) tick();
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", done_cnt - d0); end
    checks++; if ({out_best_sad, out_best_idx, out_mv_x, out_mv_y} !== {16'd9, 8'd3, 6'h3B, 6'h38}) begin
      errors++; $display("FAIL restart_best got %0d@%0d mv %h/%h exp 9@3 mv 3b/38", out_best_sad, out_best_idx, out_mv_x, out_mv_y);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    start_search();
    d0 = done_cnt;
    for (int k = 0; k < 10; k++) pulse(k % 4, 16'd5);
    checks++; if (out_best_sad !== 16'd5) begin errors++; $display("FAIL areset_pre got %0d exp 5", out_best_sad); end
    #2 in_rst = 1'b1;
    #1;
    checks++; if ({out_best_sad, out_best_idx, out_busy, out_done} !== {16'hFFFF, 8'd0, 2'b00}) begin
      errors++; $display("FAIL areset_async got %h@%0d %b%b exp ffff@0 00", out_best_sad, out_best_idx, out_busy, out_done);
    end
    repeat (2) tick();
    in_rst = 1'b0;
    repeat (300) tick();
    checks++; if ({done_cnt - d0, out_busy} !== {32'd0, 1'b0}) begin errors++; $display("FAIL areset_abandon got done %0d busy %b exp 0 0", done_cnt - d0, out_busy); end
  endtask

  initial begin
    test_reset();
    test_idle_filter();
    test_single_lane_sweep();
    test_simultaneous();
    test_tie_stored();
    test_all_ones();
    test_overflow();
    test_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
